multicycle_control: RTL and testbench

- Main control FSM for the 16-bit multicycle CPU, directly upstream of the ALU/ALUOut datapath stage.
- Decodes the latched instruction (IR) and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives ALUSrcB, AluOp, ALUOutWrite and all memory, register-file and PC enables.
- Stalls on a memory ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 80 ++++++++
 rtl/ctrl_output_decode.sv | 102 ++++++++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the multicycle control FSM
//
// Holds the FSM state enum, instruction opcodes, ALU operation codes,
// ALU B-operand select codes, PC source codes and the packed control word
// produced by ctrl_output_decode. No ports.
// The TRAP state is always part of the enum; it is only reachable when the
// OVFL_TRAP_EN macro is defined.

package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13,
        ST_TRAP     = 4'd14
    } state_t;

    // Opcodes, Instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ADDS  = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_JUMP  = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // AluOp codes (4-7 reserved)
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REGB     = 2'd0;
    localparam logic [1:0] SRCB_ZEXT     = 2'd1;
    localparam logic [1:0] SRCB_SEXT     = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH1 = 2'd3;

    // PCSource codes
    localparam logic [1:0] PCSRC_INC    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_TRAP   = 2'd3;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_word_t;

    // Only the arithmetic operations can overflow.
    function automatic logic is_add_sub(input logic [2:0] alu_op);
        return (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - combinational state/opcode/funct to control word decode
//
// Ports:
//   i_state  - current FSM state
//   i_opcode - Instr[15:12]
//   i_funct  - Instr[2:0], drives AluOp directly for R-type
//   o_ctrl   - raw control word; FETCH IRWrite/PCEn and BRANCH PCEn are
//              reported ungated, the top applies MemReady/Zero.
// Parameter TRAP_VEC_SEL is the PCSource value driven in TRAP.

module ctrl_output_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [1:0] TRAP_VEC_SEL = 2'd2
) (
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_funct,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_en     = 1'b1;
                o_ctrl.pc_source = PCSRC_INC;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = i_funct;
                o_ctrl.alu_out_write = 1'b1;
            end
            ST_WB_R: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_EXEC_I: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_out_write = 1'b1;
                case (i_opcode)
                    OP_ANDI: begin
                        o_ctrl.alu_src_b = SRCB_ZEXT;
                        o_ctrl.alu_op    = ALU_AND;
                    end
                    OP_ADDS: begin
                        o_ctrl.alu_src_b = SRCB_SEXT_SH1;
                        o_ctrl.alu_op    = ALU_ADD;
                    end
                    default: begin
                        o_ctrl.alu_src_b = SRCB_SEXT;
                        o_ctrl.alu_op    = ALU_ADD;
                    end
                endcase
            end
            ST_WB_I: begin
                o_ctrl.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_SEXT;
                o_ctrl.alu_op        = ALU_ADD;
                o_ctrl.alu_out_write = 1'b1;
            end
            ST_MEM_RD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.pc_source = PCSRC_BRANCH;
                o_ctrl.pc_en     = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_en     = 1'b1;
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            ST_TRAP: begin
                o_ctrl.pc_en     = 1'b1;
                o_ctrl.pc_source = TRAP_VEC_SEL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the 16-bit multicycle CPU
//
// Owns the state register, next-state logic, MemReady/Zero gating and the
// sticky Illegal/TrapFlag flags; control outputs come from ctrl_output_decode.
// Optional feature macro: OVFL_TRAP_EN (overflow in an ADD/SUB execute
// diverts to TRAP; when undefined ovfl is ignored and TrapFlag is 0).
//
// Ports:
//   CLK, RESET_N           - clock (rising edge), async active-low reset
//   Instr[15:0]            - IR contents: opcode [15:12], funct [2:0]
//   MemReady               - memory finished the current access this cycle
//   Zero, ovfl             - ALU status, combinational
//   IorD, MemRead, MemWrite, IRWrite, PCEn, PCSource[1:0]
//   ALUSrcA, ALUSrcB[1:0], AluOp[2:0], ALUOutWrite
//   RegWrite, RegDst, MemtoReg
//   Halted, Illegal (sticky), TrapFlag (sticky)

module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter logic [1:0] TRAP_VEC_SEL = 2'd2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] Instr,
    input  logic        MemReady,
    input  logic        Zero,
    input  logic        ovfl,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCEn,
    output logic [1:0]  PCSource,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  AluOp,
    output logic        ALUOutWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        Halted,
    output logic        Illegal,
    output logic        TrapFlag
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_set_illegal;
    logic       w_trap_take;
    logic       w_pc_gate;
    logic [3:0] w_opcode;
    logic [2:0] w_funct;
    ctrl_word_t w_ctrl;

    assign w_opcode = Instr[15:12];
    assign w_funct  = Instr[2:0];

    ctrl_output_decode #(
        .TRAP_VEC_SEL (TRAP_VEC_SEL)
    ) u_decode (
        .i_state  (r_state),
        .i_opcode (w_opcode),
        .i_funct  (w_funct),
        .o_ctrl   (w_ctrl)
    );

    // Immediate/register fields are consumed by the datapath, not here.
    logic w_unused;
    assign w_unused = &{1'b0, Instr[11:3], ovfl};

`ifdef OVFL_TRAP_EN
    assign w_trap_take = ovfl & is_add_sub(w_ctrl.alu_op);
`else
    assign w_trap_take = 1'b0;
`endif

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_RST:      w_next = ST_FETCH;
            ST_FETCH:    w_next = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_opcode)
                    OP_RTYPE:                 w_next = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ADDS: w_next = ST_EXEC_I;
                    OP_LW, OP_SW:             w_next = ST_MEM_ADDR;
                    OP_BEQ:                   w_next = ST_BRANCH;
                    OP_JUMP:                  w_next = ST_JUMP;
                    OP_HALT:                  w_next = ST_HALT;
                    default: begin
                        w_next        = ST_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            // ALUOut still loads in the trapping cycle; only writeback is skipped.
            ST_EXEC_R:   w_next = w_trap_take ? ST_TRAP : ST_WB_R;
            ST_EXEC_I:   w_next = w_trap_take ? ST_TRAP : ST_WB_I;
            ST_WB_R:     w_next = ST_FETCH;
            ST_WB_I:     w_next = ST_FETCH;
            ST_MEM_ADDR: w_next = (w_opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_next = MemReady ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WR:   w_next = MemReady ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            ST_TRAP:     w_next = ST_FETCH;
            default:     w_next = ST_RST;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_RST;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

`ifdef OVFL_TRAP_EN
    logic r_trap;
    // Set on entry so the flag is already visible during the TRAP cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_trap <= 1'b0;
        end else if (w_next == ST_TRAP) begin
            r_trap <= 1'b1;
        end
    end
    assign TrapFlag = r_trap;
`else
    assign TrapFlag = 1'b0;
`endif

    // FETCH completes only with MemReady; a branch is taken only on Zero.
    always_comb begin
        w_pc_gate = 1'b1;
        case (r_state)
            ST_FETCH:  w_pc_gate = MemReady;
            ST_BRANCH: w_pc_gate = Zero;
            default:   w_pc_gate = 1'b1;
        endcase
    end

    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write & MemReady;
    assign PCEn        = w_ctrl.pc_en & w_pc_gate;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign AluOp       = w_ctrl.alu_op;
    assign ALUOutWrite = w_ctrl.alu_out_write;
    assign RegWrite    = w_ctrl.reg_write;
    assign RegDst      = w_ctrl.reg_dst;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign Halted      = w_ctrl.halted;
    assign Illegal     = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] Instr;
    logic        MemReady, Zero, ovfl;
    logic        IorD, MemRead, MemWrite, IRWrite, PCEn;
    logic [1:0]  PCSource, ALUSrcB;
    logic        ALUSrcA;
    logic [2:0]  AluOp;
    logic        ALUOutWrite, RegWrite, RegDst, MemtoReg, Halted, Illegal, TrapFlag;

    always #5 CLK = ~CLK;

    multicycle_control #(.TRAP_VEC_SEL(2'd2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Instr(Instr), .MemReady(MemReady),
        .Zero(Zero), .ovfl(ovfl), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOp(AluOp),
        .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .Halted(Halted), .Illegal(Illegal), .TrapFlag(TrapFlag)
    );

    typedef enum int {
        P_RST, P_FETCH, P_DECODE, P_EXEC_R, P_WB_R, P_EXEC_I, P_WB_I, P_MEM_ADDR,
        P_MEM_RD, P_MEM_WB, P_MEM_WR, P_BRANCH, P_JUMP, P_HALT, P_TRAP
    } phase_t;

    typedef struct packed {
        logic       iord, mem_read, mem_write, ir_write, pc_en;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write, reg_write, reg_dst, mem_to_reg, halted, illegal, trap_flag;
    } outs_t;

    outs_t  dut_outs;
    assign dut_outs = {IorD, MemRead, MemWrite, IRWrite, PCEn, PCSource, ALUSrcA, ALUSrcB,
                       AluOp, ALUOutWrite, RegWrite, RegDst, MemtoReg, Halted, Illegal, TrapFlag};

    int     n_tests = 0;
    int     n_fail  = 0;
    outs_t  exp_row;
    phase_t exp_phase;
    bit     exp_valid = 1'b0;
    bit     m_illegal, m_trap;
    outs_t  seen [15];
    int     cyc;

    // Expected outputs for one cycle of a given instruction phase.
    function automatic outs_t spec_outputs(input phase_t p, input logic [15:0] ins,
                                           input logic mr, input logic z);
        outs_t o = '0;
        o.illegal   = m_illegal;
        o.trap_flag = m_trap;
        case (p)
            P_FETCH:    begin o.mem_read = 1; o.ir_write = mr; o.pc_en = mr; end
            P_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = ins[2:0]; o.alu_out_write = 1; end
            P_WB_R:     begin o.reg_write = 1; o.reg_dst = 1; end
            P_EXEC_I: begin
                o.alu_src_a = 1; o.alu_out_write = 1;
                if (ins[15:12] == 4'd2)      begin o.alu_src_b = 2'd1; o.alu_op = 3'd0; end
                else if (ins[15:12] == 4'd3) begin o.alu_src_b = 2'd3; o.alu_op = 3'd2; end
                else                         begin o.alu_src_b = 2'd2; o.alu_op = 3'd2; end
            end
            P_WB_I:     o.reg_write = 1;
            P_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'd2; o.alu_out_write = 1; end
            P_MEM_RD:   begin o.iord = 1; o.mem_read = 1; end
            P_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
            P_MEM_WR:   begin o.iord = 1; o.mem_write = 1; end
            P_BRANCH:   begin o.alu_src_a = 1; o.alu_op = 3'd3; o.pc_source = 2'd1; o.pc_en = z; end
            P_JUMP:     begin o.pc_source = 2'd2; o.pc_en = 1; end
            P_HALT:     o.halted = 1;
            P_TRAP:     begin o.pc_en = 1; o.pc_source = 2'd2; end
            default: ;
        endcase
        return o;
    endfunction

    // Single per-cycle compare against the model.
    always @(negedge CLK) begin
        if (exp_valid) begin
            n_tests++;
            if (dut_outs !== exp_row) begin
                n_fail++;
                $display("FAIL cycle_%s t=%0t got=%h exp=%h", exp_phase.name(), $time, dut_outs, exp_row);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        RESET_N   = 1'b0;
        m_illegal = 1'b0;
        m_trap    = 1'b0;
        exp_row   = '0;
        exp_phase = P_RST;
        exp_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_lit("reset_outs_zero", int'(dut_outs), 0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // zsel/ovsel: 0 or 1 = fixed value, 2 = random per cycle.
    task automatic run_instr(input logic [15:0] ins, input bit rnd, input int rd_stalls,
                             input int zsel, input int ovsel, input bit abort_rd,
                             output int cycles);
        phase_t seq[$];
        phase_t p;
        int     idx = 0;
        int     stalls_left = rd_stalls;
        bit     stay;
        for (int i = 0; i < 15; i++) seen[i] = '0;
        case (ins[15:12])
            4'd0:             seq = '{P_FETCH, P_DECODE, P_EXEC_R, P_WB_R};
            4'd1, 4'd2, 4'd3: seq = '{P_FETCH, P_DECODE, P_EXEC_I, P_WB_I};
            4'd4:             seq = '{P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_RD, P_MEM_WB};
            4'd5:             seq = '{P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_WR};
            4'd6:             seq = '{P_FETCH, P_DECODE, P_BRANCH};
            4'd7:             seq = '{P_FETCH, P_DECODE, P_JUMP};
            default:          seq = '{P_FETCH, P_DECODE, P_HALT, P_HALT, P_HALT, P_HALT};
        endcase
        Instr  = ins;
        cycles = 0;
        while (idx < seq.size()) begin
            p = seq[idx];
            MemReady = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!rnd && p == P_MEM_RD && stalls_left > 0) begin
                MemReady = 1'b0;
                stalls_left--;
            end
            Zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
            ovfl = (ovsel == 2) ? 1'($urandom_range(0, 1)) : (ovsel == 1);
            if (p == P_HALT && ins[15:12] != 4'hF) m_illegal = 1'b1;
            if (p == P_TRAP) m_trap = 1'b1;
            exp_row   = spec_outputs(p, ins, MemReady, Zero);
            exp_phase = p;
            exp_valid = 1'b1;
            @(negedge CLK);
            #1;
            seen[p] = dut_outs;
            if (abort_rd && p == P_MEM_RD) begin
                exp_valid = 1'b0;
                check_lit("memread_before_reset", int'(MemRead), 1);
                RESET_N = 1'b0;
                #1;
                check_lit("memread_drops_on_reset", int'(MemRead), 0);
                check_lit("outs_zero_on_reset", int'(dut_outs), 0);
                return;
            end
            @(posedge CLK);
            #1;
            cycles++;
            if (cycles > 200) begin
                check_lit("instr_cycle_budget", cycles, 200);
                return;
            end
            stay = (p == P_FETCH || p == P_MEM_RD || p == P_MEM_WR) && !MemReady;
            if (!stay) begin
`ifdef OVFL_TRAP_EN
                if ((p == P_EXEC_R || p == P_EXEC_I) && ovfl &&
                    (exp_row.alu_op == 3'd2 || exp_row.alu_op == 3'd3))
                    seq[idx + 1] = P_TRAP;
`endif
                idx++;
            end
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        Instr    = '0;
        MemReady = 1'b0;
        Zero     = 1'b0;
        ovfl     = 1'b0;
        do_reset();

        run_instr(16'h1105, 0, 0, 0, 0, 0, cyc);
        check_lit("addi_cycles", cyc, 4);
        check_lit("addi_srcb", int'(seen[P_EXEC_I].alu_src_b), 2);
        check_lit("addi_aluop", int'(seen[P_EXEC_I].alu_op), 2);
        check_lit("addi_aluoutwrite", int'(seen[P_EXEC_I].alu_out_write), 1);
        check_lit("addi_wb_regwrite", int'(seen[P_WB_I].reg_write), 1);
        check_lit("addi_wb_regdst", int'(seen[P_WB_I].reg_dst), 0);

        run_instr(16'h00F0, 0, 0, 0, 0, 0, cyc);
        check_lit("rtype_cycles", cyc, 4);
        check_lit("rtype_srcb", int'(seen[P_EXEC_R].alu_src_b), 0);
        check_lit("rtype_aluop", int'(seen[P_EXEC_R].alu_op), 0);

        run_instr(16'h2AFF, 0, 0, 0, 0, 0, cyc);
        check_lit("andi_srcb", int'(seen[P_EXEC_I].alu_src_b), 1);
        check_lit("andi_aluop", int'(seen[P_EXEC_I].alu_op), 0);

        run_instr(16'h3AFF, 0, 0, 0, 0, 0, cyc);
        check_lit("adds_srcb", int'(seen[P_EXEC_I].alu_src_b), 3);
        check_lit("adds_aluop", int'(seen[P_EXEC_I].alu_op), 2);

        run_instr(16'h4105, 0, 2, 0, 0, 0, cyc);
        check_lit("lw_stall_cycles", cyc, 7);
        check_lit("lw_memwb_memtoreg", int'(seen[P_MEM_WB].mem_to_reg), 1);
        check_lit("lw_memwb_regwrite", int'(seen[P_MEM_WB].reg_write), 1);

        run_instr(16'h5105, 0, 0, 0, 0, 0, cyc);
        check_lit("sw_cycles", cyc, 4);

        run_instr(16'h6012, 0, 0, 1, 0, 0, cyc);
        check_lit("beq_cycles", cyc, 3);
        check_lit("beq_taken_pcen", int'(seen[P_BRANCH].pc_en), 1);
        check_lit("beq_taken_pcsrc", int'(seen[P_BRANCH].pc_source), 1);
        run_instr(16'h6012, 0, 0, 0, 0, 0, cyc);
        check_lit("beq_not_taken_pcen", int'(seen[P_BRANCH].pc_en), 0);

        run_instr(16'h7123, 0, 0, 0, 0, 0, cyc);
        check_lit("jump_cycles", cyc, 3);

        run_instr(16'h1105, 0, 0, 0, 1, 0, cyc);
`ifdef OVFL_TRAP_EN
        check_lit("trap_no_regwrite", int'(seen[P_WB_I].reg_write), 0);
        check_lit("trap_pcen", int'(seen[P_TRAP].pc_en), 1);
        check_lit("trap_pcsrc", int'(seen[P_TRAP].pc_source), 2);
        check_lit("trap_flag", int'(seen[P_TRAP].trap_flag), 1);
`else
        check_lit("ovfl_ignored_regwrite", int'(seen[P_WB_I].reg_write), 1);
        check_lit("ovfl_ignored_trapflag", int'(TrapFlag), 0);
`endif

        run_instr(16'hA000, 0, 0, 0, 0, 0, cyc);
        check_lit("illegal_halted", int'(seen[P_HALT].halted), 1);
        check_lit("illegal_flag", int'(seen[P_HALT].illegal), 1);
        do_reset();

        run_instr(16'h4105, 0, 5, 0, 0, 1, cyc);
        do_reset();

        for (int n = 0; n < 250; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            run_instr({op, 12'($urandom)}, 1, 0, 2, 2, 0, cyc);
            if (op >= 4'd8) do_reset();
        end

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
